instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles allowed for MFC before a fault (range 1..255).
REQ-002 The block SHALL have parameter PC_STEP, default 4, meaning the byte increment applied to the fetched address.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port FETCH_EN, input, 1 bit: control-unit request to fetch the next instruction.
REQ-006 The block SHALL have port PC_in, input, 32 bits: current PC, taken from the register-file PCout.
REQ-007 The block SHALL have port MEM_DATA, input, 32 bits: instruction word returned by memory.
REQ-008 The block SHALL have port MFC, input, 1 bit: memory-function-complete; MEM_DATA is valid while it is high.
REQ-009 The block SHALL have port MAR_OUT, output, 32 bits: fetch address presented to memory.
REQ-010 The block SHALL have port MOV, output, 1 bit: memory read request.
REQ-011 The block SHALL have port Pcin, output, 32 bits: next-PC value for the register file.
REQ-012 The block SHALL have port LOADPC, output, 1 bit: one-cycle PC-load strobe to the register file.
REQ-013 The block SHALL have port IR, output, 32 bits: latched instruction.
REQ-014 The block SHALL have port RSLCT, output, 20 bits: register selects {IR[19:16], IR[15:12], IR[11:8], IR[7:4], IR[3:0]}.
REQ-015 The block SHALL have port IR_VALID, output, 1 bit: IR holds a completed fetch.
REQ-016 The block SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.
REQ-017 The block SHALL have port FAULT, output, 1 bit: sticky memory-timeout flag.

Function
REQ-018 The block SHALL implement three FSM states: IDLE, WAIT and UPDATE; all outputs except BUSY and RSLCT SHALL be registered.
REQ-019 In IDLE with FETCH_EN high at an edge, the block SHALL set MAR_OUT<=PC_in, MOV<=1, IR_VALID<=0, FAULT<=0, clear the wait counter and enter WAIT.
REQ-020 In WAIT with MFC high at an edge, the block SHALL set IR<=MEM_DATA, MOV<=0, LOADPC<=1, Pcin<=MAR_OUT+PC_STEP (modulo 2^32, wrapping at 0xFFFFFFFC) and IR_VALID<=1, and SHALL enter UPDATE.
REQ-021 In WAIT with MFC low, the block SHALL increment the wait counter and SHALL hold MOV high and MAR_OUT stable.
REQ-022 When the wait counter reaches TIMEOUT without MFC, the block SHALL set MOV<=0 and FAULT<=1, leave IR unchanged, keep IR_VALID at 0, and return to IDLE.
REQ-023 In UPDATE, the block SHALL set LOADPC<=0 at the next edge and return to IDLE; LOADPC SHALL therefore be high for exactly one cycle per successful fetch.
REQ-024 The minimum latency SHALL be: FETCH_EN sampled at edge k, MFC sampled at edge k+1, LOADPC high between edges k+1 and k+2, and IDLE re-entered at edge k+2.
REQ-025 The block SHALL ignore FETCH_EN while not in IDLE, and SHALL ignore MFC while not in WAIT.
REQ-026 IR_VALID SHALL remain high until the next accepted FETCH_EN; FAULT SHALL remain high until the next accepted FETCH_EN or RESET.
REQ-027 RSLCT SHALL be a pure bit selection of IR.

Reset
REQ-028 While RESET is high, the block SHALL immediately force state IDLE; MAR_OUT, Pcin and IR to 0; MOV, LOADPC, IR_VALID and FAULT to 0; and the wait counter to 0.
REQ-029 RESET asserted during WAIT or UPDATE SHALL abort the fetch with no LOADPC pulse after reset release.

Structure
REQ-030 The FSM state encoding, PC_STEP and the default TIMEOUT SHALL live in the shared CPU package.
REQ-031 The wait counter SHALL be one sub-module, fetch_timeout_counter, with inputs clear and enable, and output expired.

Verification
REQ-032 Scenario 1: PC_in=0x100, FETCH_EN pulse, MFC high 3 cycles later with MEM_DATA=0xE0821003 -> IR=0xE0821003, RSLCT=0x21003 (fields 2,1,0,0,3), Pcin=0x104, one LOADPC cycle, IR_VALID=1.
REQ-033 Scenario 2: PC_in=0xFFFFFFFC, MFC on the first WAIT cycle -> Pcin=0x00000000, IDLE reached 2 cycles after FETCH_EN.
REQ-034 Scenario 3: MFC never asserted, TIMEOUT=15 -> MOV high for exactly 15 cycles, then FAULT=1, IR unchanged, LOADPC never high; the next FETCH_EN clears FAULT.
REQ-035 Scenario 4: FETCH_EN held high throughout, plus a stray MFC pulse in IDLE -> exactly one fetch per IDLE visit, and the stray MFC has no effect.
REQ-036 Scenario 5: RESET asserted mid-WAIT, with MFC arriving afterwards -> all outputs are 0 immediately, and there is no IR load and no LOADPC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: FSM encoding, PC step and
// default memory timeout.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StUpdate = 2'd2
  } fetch_state_e;

  localparam int unsigned PcStep         = 4;
  localparam int unsigned DefaultTimeout = 15;
  localparam int unsigned TimeoutCntW    = 8;

endpackage

// File: rtl/instruction_fetch_unit_fetch_timeout_counter.sv
// Counts WAIT cycles without MFC; expired flags the last permitted WAIT cycle.
module fetch_timeout_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic Clk,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TimeoutCntW-1:0] count_q;

  // count_q == TIMEOUT-1 means this WAIT cycle is the TIMEOUT-th one.
  assign expired = (count_q == TimeoutCntW'(TIMEOUT - 1));

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch FSM: issues a memory read at PC, waits for MFC or timeout, latches IR
// and pulses LOADPC with the incremented PC.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned PC_STEP = PcStep
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        FETCH_EN,
  input  logic [31:0] PC_in,
  input  logic [31:0] MEM_DATA,
  input  logic        MFC,
  output logic [31:0] MAR_OUT,
  output logic        MOV,
  output logic [31:0] Pcin,
  output logic        LOADPC,
  output logic [31:0] IR,
  output logic [19:0] RSLCT,
  output logic        IR_VALID,
  output logic        BUSY,
  output logic        FAULT
);

  fetch_state_e state_q;
  logic         expired;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .Clk    (Clk),
    .RESET  (RESET),
    .clear  (state_q != StWait),
    .enable ((state_q == StWait) && !MFC),
    .expired(expired)
  );

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      MAR_OUT  <= '0;
      MOV      <= 1'b0;
      Pcin     <= '0;
      LOADPC   <= 1'b0;
      IR       <= '0;
      IR_VALID <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (FETCH_EN) begin
            MAR_OUT  <= PC_in;
            MOV      <= 1'b1;
            IR_VALID <= 1'b0;
            FAULT    <= 1'b0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          // MFC wins over a timeout on the same edge.
          if (MFC) begin
            IR       <= MEM_DATA;
            MOV      <= 1'b0;
            LOADPC   <= 1'b1;
            Pcin     <= MAR_OUT + 32'(PC_STEP);
            IR_VALID <= 1'b1;
            state_q  <= StUpdate;
          end else if (expired) begin
            MOV     <= 1'b0;
            FAULT   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StUpdate: begin
          LOADPC  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BUSY  = (state_q != StIdle);
  assign RSLCT = {IR[19:16], IR[15:12], IR[11:8], IR[7:4], IR[3:0]};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected fetch outcomes,
// a negedge monitor pops and compares on each LOADPC pulse or FAULT assertion.
module tb_instruction_fetch_unit;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned PC_STEP = 4;

  logic        Clk;
  logic        RESET;
  logic        FETCH_EN;
  logic [31:0] PC_in;
  logic [31:0] MEM_DATA;
  logic        MFC;
  logic [31:0] MAR_OUT;
  logic        MOV;
  logic [31:0] Pcin;
  logic        LOADPC;
  logic [31:0] IR;
  logic [19:0] RSLCT;
  logic        IR_VALID;
  logic        BUSY;
  logic        FAULT;

  instruction_fetch_unit #(
    .TIMEOUT(TIMEOUT),
    .PC_STEP(PC_STEP)
  ) dut (
    .Clk     (Clk),
    .RESET   (RESET),
    .FETCH_EN(FETCH_EN),
    .PC_in   (PC_in),
    .MEM_DATA(MEM_DATA),
    .MFC     (MFC),
    .MAR_OUT (MAR_OUT),
    .MOV     (MOV),
    .Pcin    (Pcin),
    .LOADPC  (LOADPC),
    .IR      (IR),
    .RSLCT   (RSLCT),
    .IR_VALID(IR_VALID),
    .BUSY    (BUSY),
    .FAULT   (FAULT)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_fault;
    logic [31:0] mar;
    logic [31:0] ir;
    logic [31:0] pcin;
    int          mov_len;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          held = 0;
  logic [31:0] model_ir = '0;
  logic [31:0] model_pcin = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] reg_selects(input logic [31:0] ir);
    logic [31:0] r = '0;
    for (int i = 0; i < 5; i++) r |= ((ir >> (4 * i)) & 32'hF) << (4 * i);
    return r;
  endfunction

  // One fetch transaction. delay = WAIT cycles with MFC low before MFC; >= TIMEOUT means never.
  // Entered and left at posedge+1 with the DUT idle.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int delay,
                       input bit stray);
    exp_t e;
    bit   fault;
    fault     = (delay >= int'(TIMEOUT));
    e.is_fault = fault;
    e.mar      = pc;
    e.ir       = fault ? model_ir : data;
    e.pcin     = fault ? model_pcin : pc + PC_STEP;
    e.mov_len  = fault ? int'(TIMEOUT) : delay + 1;
    sb.push_back(e);
    if (!fault) begin
      model_ir   = data;
      model_pcin = pc + PC_STEP;
    end
    FETCH_EN = 1'b1;
    PC_in    = pc;
    MFC      = stray;
    MEM_DATA = $urandom;
    @(posedge Clk); #1;
    if (!held) FETCH_EN = 1'b0;
    MFC   = 1'b0;
    PC_in = $urandom;
    if (fault) begin
      repeat (TIMEOUT) begin @(posedge Clk); #1; end
    end else begin
      repeat (delay) begin @(posedge Clk); #1; end
      MFC      = 1'b1;
      MEM_DATA = data;
      @(posedge Clk); #1;
      MFC      = 1'b0;
      MEM_DATA = $urandom;
      @(posedge Clk); #1;
    end
  endtask

  task automatic random_fetch();
    int r;
    int d;
    r = $urandom_range(0, 9);
    if (r < 6) d = $urandom_range(0, 5);
    else if (r < 8) d = TIMEOUT - 1;
    else d = TIMEOUT;
    fetch($urandom & 32'hFFFF_FFFC, $urandom, d, ($urandom_range(0, 2) == 0));
  endtask

  // Monitor
  initial begin
    int   mov_run = 0;
    bit   prev_mov = 0, prev_loadpc = 0, prev_fault = 0, after_chk = 0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (RESET) begin
        mov_run = 0; prev_mov = 0; prev_loadpc = 0; prev_fault = 0; after_chk = 0;
      end else begin
        if (after_chk) begin
          chk("idle_after_update", BUSY, 0);
          chk("loadpc_one_cycle", LOADPC, 0);
          after_chk = 0;
        end
        if (MOV && !prev_mov) begin
          chk("fault_cleared_on_fetch", FAULT, 0);
          chk("ir_valid_cleared_on_fetch", IR_VALID, 0);
        end
        if (LOADPC && !prev_loadpc) begin
          if (sb.size() == 0) begin
            chk("unexpected_loadpc", LOADPC, 0);
          end else begin
            e = sb.pop_front();
            chk("loadpc_not_fault", 32'(e.is_fault), 0);
            chk("mar", MAR_OUT, e.mar);
            chk("ir", IR, e.ir);
            chk("pcin", Pcin, e.pcin);
            chk("rslct", 32'(RSLCT), reg_selects(e.ir));
            chk("ir_valid", IR_VALID, 1);
            chk("mov_low", MOV, 0);
            chk("mov_cycles", mov_run, e.mov_len);
            chk("fault_low", FAULT, 0);
            after_chk = 1;
          end
        end
        if (FAULT && !prev_fault) begin
          if (sb.size() == 0) begin
            chk("unexpected_fault", FAULT, 0);
          end else begin
            e = sb.pop_front();
            chk("fault_expected", 32'(e.is_fault), 1);
            chk("fault_mar", MAR_OUT, e.mar);
            chk("fault_ir_unchanged", IR, e.ir);
            chk("fault_pcin_unchanged", Pcin, e.pcin);
            chk("fault_ir_valid", IR_VALID, 0);
            chk("fault_busy", BUSY, 0);
            chk("fault_loadpc", LOADPC, 0);
            chk("fault_mov_cycles", mov_run, e.mov_len);
          end
        end
        mov_run     = MOV ? mov_run + 1 : 0;
        prev_mov    = MOV;
        prev_loadpc = LOADPC;
        prev_fault  = FAULT;
      end
    end
  end

  initial begin
    RESET    = 1'b1;
    FETCH_EN = 1'b0;
    PC_in    = '0;
    MEM_DATA = '0;
    MFC      = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_mar", MAR_OUT, 0);
    chk("rst_pcin", Pcin, 0);
    chk("rst_ir", IR, 0);
    chk("rst_mov", MOV, 0);
    chk("rst_loadpc", LOADPC, 0);
    chk("rst_ir_valid", IR_VALID, 0);
    chk("rst_fault", FAULT, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;
    @(posedge Clk); #1;

    // Directed scenarios
    fetch(32'h0000_0100, 32'hE082_1003, 2, 0);
    chk("s1_rslct_vector", 32'(RSLCT), 32'h0002_1003);
    fetch(32'hFFFF_FFFC, $urandom, 0, 0);
    fetch(32'h0000_0200, $urandom, TIMEOUT, 0);
    fetch(32'h0000_0300, $urandom, TIMEOUT - 1, 1);

    // FETCH_EN held high with stray MFC in IDLE
    held = 1;
    fetch(32'h0000_0400, $urandom, 0, 1);
    fetch(32'h0000_0404, $urandom, 3, 1);
    fetch(32'h0000_0408, $urandom, TIMEOUT, 1);
    fetch(32'h0000_040C, $urandom, 1, 0);
    held = 0;
    FETCH_EN = 1'b0;
    repeat (2) begin @(posedge Clk); #1; end

    // Randomized traffic, alternating held and pulsed FETCH_EN
    for (int blk = 0; blk < 6; blk++) begin
      held = blk[0];
      for (int i = 0; i < 7; i++) random_fetch();
      held = 0;
      FETCH_EN = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge Clk); #1; end
    end

    // Reset mid-WAIT, MFC arriving afterwards
    FETCH_EN = 1'b1;
    PC_in    = 32'h0000_0500;
    @(posedge Clk); #1;
    FETCH_EN = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    RESET = 1'b1;
    #1;
    chk("s5_mov", MOV, 0);
    chk("s5_mar", MAR_OUT, 0);
    chk("s5_busy", BUSY, 0);
    chk("s5_ir", IR, 0);
    chk("s5_pcin", Pcin, 0);
    chk("s5_ir_valid", IR_VALID, 0);
    MFC      = 1'b1;
    MEM_DATA = $urandom;
    repeat (2) begin @(posedge Clk); #1; end
    RESET      = 1'b0;
    model_ir   = '0;
    model_pcin = '0;
    repeat (3) begin @(posedge Clk); #1; end
    MFC = 1'b0;
    chk("s5_post_ir", IR, 0);
    chk("s5_post_loadpc", LOADPC, 0);
    chk("s5_post_busy", BUSY, 0);

    fetch(32'h0000_0600, $urandom, TIMEOUT, 0);
    fetch(32'h0000_0604, $urandom, 4, 0);

    repeat (4) @(posedge Clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
